// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Entries carry an acceptance stamp used for wrap-aware age comparison.
package regfile_wb_arbiter_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 3;
  localparam int STAMP_W    = 3;
  // No buffered entry waits longer than this, so stamps never alias.
  localparam int MAX_AGE    = 3;

  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_MEM = 1'b1;

  typedef logic [STAMP_W-1:0] stamp_t;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
    stamp_t                stamp;
  } wb_entry_t;

  // True when stamp a was taken strictly earlier than stamp b.
  function automatic logic stamp_older(input stamp_t a, input stamp_t b);
    stamp_t d;
    d = b - a;
    return (d != '0) && (d <= stamp_t'(MAX_AGE));
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_fifo.sv
// DEPTH-entry synchronous FIFO holding pending writebacks for one requester,
// exposing its head and a per-entry valid/address view for hazard tracking.
module wb_fifo
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 2
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     push,
  input  logic [ADDR_W-1:0]        push_addr,
  input  logic [DATA_W-1:0]        push_data,
  input  stamp_t                   push_stamp,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [ADDR_W-1:0]        head_addr,
  output logic [DATA_W-1:0]        head_data,
  output stamp_t                   head_stamp,
  output logic [DEPTH-1:0]         ent_valid,
  output logic [DEPTH*ADDR_W-1:0]  ent_addr
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] addr_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem  [DEPTH];
  stamp_t            stamp_mem [DEPTH];

  logic [PTR_W:0] wr_ptr;
  logic [PTR_W:0] rd_ptr;
  logic [PTR_W:0] count;
  logic           do_push;
  logic           do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) begin
      addr_mem[wr_ptr[PTR_W-1:0]]  <= push_addr;
      data_mem[wr_ptr[PTR_W-1:0]]  <= push_data;
      stamp_mem[wr_ptr[PTR_W-1:0]] <= push_stamp;
    end
  end

  assign head_addr  = addr_mem[rd_ptr[PTR_W-1:0]];
  assign head_data  = data_mem[rd_ptr[PTR_W-1:0]];
  assign head_stamp = stamp_mem[rd_ptr[PTR_W-1:0]];

  // A slot is live when its distance from the read pointer is below the fill level.
  always_comb begin
    ent_valid = '0;
    ent_addr  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_valid[i] = ({1'b0, PTR_W'(i) - rd_ptr[PTR_W-1:0]} < count);
      ent_addr[i*ADDR_W +: ADDR_W] = addr_mem[i];
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register file's single write port between the ALU and load
// writeback stages, oldest first, and reports registers with writes in flight.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 2
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    alu_valid,
  output logic                    alu_ready,
  input  logic [ADDR_W-1:0]       alu_addr,
  input  logic [DATA_W-1:0]       alu_data,
  input  logic                    mem_valid,
  output logic                    mem_ready,
  input  logic [ADDR_W-1:0]       mem_addr,
  input  logic [DATA_W-1:0]       mem_data,
  output logic                    wr_en,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [DATA_W-1:0]       wr_data,
  output logic [(2**ADDR_W)-1:0]  pend_mask
);

  stamp_t cnt;
  logic   rr;
  logic   rr_nxt;

  logic                    alu_full, alu_empty, mem_full, mem_empty;
  logic                    alu_push, mem_push, alu_pop, mem_pop;
  logic [ADDR_W-1:0]       alu_head_addr, mem_head_addr;
  logic [DATA_W-1:0]       alu_head_data, mem_head_data;
  stamp_t                  alu_head_stamp, mem_head_stamp;
  logic [DEPTH-1:0]        alu_ent_valid, mem_ent_valid;
  logic [DEPTH*ADDR_W-1:0] alu_ent_addr, mem_ent_addr;

  logic              gnt_any;
  logic              gnt_id;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  // A full buffer refuses even when it drains in the same cycle.
  assign alu_ready = !alu_full && !RESET;
  assign mem_ready = !mem_full && !RESET;
  assign alu_push  = alu_valid && alu_ready;
  assign mem_push  = mem_valid && mem_ready;

  wb_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_alu_fifo (
    .CLK        (CLK),
    .RESET      (RESET),
    .push       (alu_push),
    .push_addr  (alu_addr),
    .push_data  (alu_data),
    .push_stamp (cnt),
    .pop        (alu_pop),
    .full       (alu_full),
    .empty      (alu_empty),
    .head_addr  (alu_head_addr),
    .head_data  (alu_head_data),
    .head_stamp (alu_head_stamp),
    .ent_valid  (alu_ent_valid),
    .ent_addr   (alu_ent_addr)
  );

  wb_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_mem_fifo (
    .CLK        (CLK),
    .RESET      (RESET),
    .push       (mem_push),
    .push_addr  (mem_addr),
    .push_data  (mem_data),
    .push_stamp (cnt),
    .pop        (mem_pop),
    .full       (mem_full),
    .empty      (mem_empty),
    .head_addr  (mem_head_addr),
    .head_data  (mem_head_data),
    .head_stamp (mem_head_stamp),
    .ent_valid  (mem_ent_valid),
    .ent_addr   (mem_ent_addr)
  );

  // Same-stamp, same-register ties go to the load: it is older in program order.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = REQ_ALU;
    rr_nxt  = rr;
    if (!alu_empty && !mem_empty) begin
      gnt_any = 1'b1;
      if (alu_head_stamp != mem_head_stamp) begin
        gnt_id = stamp_older(alu_head_stamp, mem_head_stamp) ? REQ_ALU : REQ_MEM;
      end else if (alu_head_addr == mem_head_addr) begin
        gnt_id = REQ_MEM;
      end else begin
        gnt_id = rr;
        rr_nxt = ~rr;
      end
    end else if (!alu_empty) begin
      gnt_any = 1'b1;
      gnt_id  = REQ_ALU;
    end else if (!mem_empty) begin
      gnt_any = 1'b1;
      gnt_id  = REQ_MEM;
    end
  end

  assign alu_pop  = gnt_any && (gnt_id == REQ_ALU);
  assign mem_pop  = gnt_any && (gnt_id == REQ_MEM);
  assign sel_addr = (gnt_id == REQ_MEM) ? mem_head_addr : alu_head_addr;
  assign sel_data = (gnt_id == REQ_MEM) ? mem_head_data : alu_head_data;

  // Output stage: registered write port, address and data hold when idle.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt     <= '0;
      rr      <= REQ_ALU;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      cnt   <= cnt + stamp_t'(1);
      rr    <= rr_nxt;
      wr_en <= gnt_any;
      if (gnt_any) begin
        wr_addr <= sel_addr;
        wr_data <= sel_data;
      end
    end
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (alu_ent_valid[i]) pend_mask[alu_ent_addr[i*ADDR_W +: ADDR_W]] = 1'b1;
      if (mem_ent_valid[i]) pend_mask[mem_ent_addr[i*ADDR_W +: ADDR_W]] = 1'b1;
    end
    if (wr_en) pend_mask[wr_addr] = 1'b1;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, then a cycle-level
// queue model driving a scoreboard of expected register-file writes.
module tb_regfile_wb_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 2;

  logic              CLK = 1'b0;
  logic              RESET;
  logic              alu_valid, alu_ready, mem_valid, mem_ready;
  logic [ADDR_W-1:0] alu_addr, mem_addr, wr_addr;
  logic [DATA_W-1:0] alu_data, mem_data, wr_data;
  logic              wr_en;
  logic [7:0]        pend_mask;

  regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_addr  (alu_addr),
    .alu_data  (alu_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .pend_mask (pend_mask)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Directed vectors: inputs before an edge, outputs expected just after it.
  typedef struct {
    logic        av;
    logic [2:0]  aa;
    logic [31:0] ad;
    logic        mv;
    logic [2:0]  ma;
    logic [31:0] md;
    logic        we;
    logic [2:0]  wa;
    logic [31:0] wd;
    logic [7:0]  pm;
  } vec_t;

  localparam int NV = 19;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic av, input logic [2:0] aa, input logic [31:0] ad,
                              input logic mv, input logic [2:0] ma, input logic [31:0] md,
                              input logic we, input logic [2:0] wa, input logic [31:0] wd,
                              input logic [7:0] pm);
    vec_t v;
    v.av = av; v.aa = aa; v.ad = ad; v.mv = mv; v.ma = ma; v.md = md;
    v.we = we; v.wa = wa; v.wd = wd; v.pm = pm;
    return v;
  endfunction

  // Reference model: per-requester queues tagged with absolute acceptance cycle.
  typedef struct packed {
    logic [2:0]  addr;
    logic [31:0] data;
    int          t;
  } ment_t;

  typedef struct packed {
    logic [2:0]  addr;
    logic [31:0] data;
  } wr_t;

  ment_t       aq[$];
  ment_t       mq[$];
  wr_t         exp_q[$];
  logic        m_out_en;
  logic [2:0]  m_out_addr;
  logic [31:0] m_out_data;
  logic        m_rr;
  int          m_cyc;

  task automatic model_reset();
    aq.delete();
    mq.delete();
    exp_q.delete();
    m_out_en   = 1'b0;
    m_out_addr = '0;
    m_out_data = '0;
    m_rr       = 1'b0;
    m_cyc      = 0;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic sb_step(input logic av, input logic [2:0] aa, input logic [31:0] ad,
                         input logic mv, input logic [2:0] ma, input logic [31:0] md);
    logic  g_any, g_mem, acc_a, acc_m;
    ment_t e;
    wr_t   w;
    logic [7:0] pm;
    alu_valid = av; alu_addr = aa; alu_data = ad;
    mem_valid = mv; mem_addr = ma; mem_data = md;
    #1;
    check("sb_alu_ready", 32'(alu_ready), 32'(aq.size() < DEPTH));
    check("sb_mem_ready", 32'(mem_ready), 32'(mq.size() < DEPTH));
    g_any = 1'b0;
    g_mem = 1'b0;
    if (aq.size() != 0 && mq.size() != 0) begin
      g_any = 1'b1;
      if (aq[0].t != mq[0].t)            g_mem = (mq[0].t < aq[0].t);
      else if (aq[0].addr == mq[0].addr) g_mem = 1'b1;
      else begin
        g_mem = m_rr;
        m_rr  = ~m_rr;
      end
    end else if (aq.size() != 0) begin
      g_any = 1'b1;
    end else if (mq.size() != 0) begin
      g_any = 1'b1;
      g_mem = 1'b1;
    end
    acc_a = av && (aq.size() < DEPTH);
    acc_m = mv && (mq.size() < DEPTH);
    @(posedge CLK);
    if (g_any) begin
      if (g_mem) e = mq.pop_front();
      else       e = aq.pop_front();
      m_out_en   = 1'b1;
      m_out_addr = e.addr;
      m_out_data = e.data;
      exp_q.push_back('{addr: e.addr, data: e.data});
    end else begin
      m_out_en = 1'b0;
    end
    if (acc_a) aq.push_back('{addr: aa, data: ad, t: m_cyc});
    if (acc_m) mq.push_back('{addr: ma, data: md, t: m_cyc});
    m_cyc++;
    #1;
    check("sb_wr_en", 32'(wr_en), 32'(m_out_en));
    if (wr_en) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_write", 32'(wr_addr), 32'hFFFF_FFFF);
      end else begin
        w = exp_q.pop_front();
        check("sb_wr_addr", 32'(wr_addr), 32'(w.addr));
        check("sb_wr_data", wr_data, w.data);
      end
    end
    pm = '0;
    foreach (aq[i]) pm[aq[i].addr] = 1'b1;
    foreach (mq[i]) pm[mq[i].addr] = 1'b1;
    if (m_out_en) pm[m_out_addr] = 1'b1;
    check("sb_pend_mask", 32'(pend_mask), 32'(pm));
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) sb_step(1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0);
  endtask

  // Called at a falling edge with the DUT possibly busy.
  task automatic apply_reset();
    RESET = 1'b1;
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    #1;
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_pend_mask", 32'(pend_mask), 32'd0);
    check("rst_alu_ready", 32'(alu_ready), 32'd0);
    check("rst_mem_ready", 32'(mem_ready), 32'd0);
    model_reset();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  initial begin
    tbl[0]  = mk(1'b1, 3'd3, 32'hDEADBEEF, 1'b0, 3'd0, 32'h0,  1'b0, 3'd0, 32'h0,        8'h08);
    tbl[1]  = mk(1'b0, 3'd0, 32'h0,        1'b0, 3'd0, 32'h0,  1'b1, 3'd3, 32'hDEADBEEF, 8'h08);
    tbl[2]  = mk(1'b0, 3'd0, 32'h0,        1'b0, 3'd0, 32'h0,  1'b0, 3'd3, 32'hDEADBEEF, 8'h00);
    tbl[3]  = mk(1'b1, 3'd2, 32'h11,       1'b1, 3'd2, 32'h22, 1'b0, 3'd3, 32'hDEADBEEF, 8'h04);
    tbl[4]  = mk(1'b0, 3'd0, 32'h0,        1'b0, 3'd0, 32'h0,  1'b1, 3'd2, 32'h22,       8'h04);
    tbl[5]  = mk(1'b0, 3'd0, 32'h0,        1'b0, 3'd0, 32'h0,  1'b1, 3'd2, 32'h11,       8'h04);
    tbl[6]  = mk(1'b0, 3'd0, 32'h0,        1'b0, 3'd0, 32'h0,  1'b0, 3'd2, 32'h11,       8'h00);
    tbl[7]  = mk(1'b1, 3'd5, 32'h55,       1'b0, 3'd0, 32'h0,  1'b0, 3'd2, 32'h11,       8'h20);
    tbl[8]  = mk(1'b0, 3'd0, 32'h0,        1'b1, 3'd6, 32'h66, 1'b1, 3'd5, 32'h55,       8'h60);
    tbl[9]  = mk(1'b0, 3'd0, 32'h0,        1'b0, 3'd0, 32'h0,  1'b1, 3'd6, 32'h66,       8'h40);
    tbl[10] = mk(1'b0, 3'd0, 32'h0,        1'b0, 3'd0, 32'h0,  1'b0, 3'd6, 32'h66,       8'h00);
    tbl[11] = mk(1'b1, 3'd1, 32'h01,       1'b1, 3'd4, 32'h04, 1'b0, 3'd6, 32'h66,       8'h12);
    tbl[12] = mk(1'b0, 3'd0, 32'h0,        1'b0, 3'd0, 32'h0,  1'b1, 3'd1, 32'h01,       8'h12);
    tbl[13] = mk(1'b0, 3'd0, 32'h0,        1'b0, 3'd0, 32'h0,  1'b1, 3'd4, 32'h04,       8'h10);
    tbl[14] = mk(1'b0, 3'd0, 32'h0,        1'b0, 3'd0, 32'h0,  1'b0, 3'd4, 32'h04,       8'h00);
    tbl[15] = mk(1'b1, 3'd7, 32'h77,       1'b1, 3'd0, 32'h00, 1'b0, 3'd4, 32'h04,       8'h81);
    tbl[16] = mk(1'b0, 3'd0, 32'h0,        1'b0, 3'd0, 32'h0,  1'b1, 3'd0, 32'h00,       8'h81);
    tbl[17] = mk(1'b0, 3'd0, 32'h0,        1'b0, 3'd0, 32'h0,  1'b1, 3'd7, 32'h77,       8'h80);
    tbl[18] = mk(1'b0, 3'd0, 32'h0,        1'b0, 3'd0, 32'h0,  1'b0, 3'd7, 32'h77,       8'h00);

    RESET = 1'b1;
    alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
    mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
    model_reset();
    repeat (3) @(negedge CLK);
    check("por_wr_en", 32'(wr_en), 32'd0);
    check("por_wr_addr", 32'(wr_addr), 32'd0);
    check("por_wr_data", wr_data, 32'd0);
    check("por_pend_mask", 32'(pend_mask), 32'd0);
    check("por_alu_ready", 32'(alu_ready), 32'd0);
    check("por_mem_ready", 32'(mem_ready), 32'd0);
    RESET = 1'b0;

    for (int i = 0; i < NV; i++) begin
      alu_valid = tbl[i].av; alu_addr = tbl[i].aa; alu_data = tbl[i].ad;
      mem_valid = tbl[i].mv; mem_addr = tbl[i].ma; mem_data = tbl[i].md;
      #1;
      check($sformatf("tbl%0d_alu_ready", i), 32'(alu_ready), 32'd1);
      check($sformatf("tbl%0d_mem_ready", i), 32'(mem_ready), 32'd1);
      @(posedge CLK);
      #1;
      check($sformatf("tbl%0d_wr_en", i), 32'(wr_en), 32'(tbl[i].we));
      check($sformatf("tbl%0d_wr_addr", i), 32'(wr_addr), 32'(tbl[i].wa));
      check($sformatf("tbl%0d_wr_data", i), wr_data, tbl[i].wd);
      check($sformatf("tbl%0d_pend_mask", i), 32'(pend_mask), 32'(tbl[i].pm));
      @(negedge CLK);
    end

    apply_reset();

    // Same-cycle requests to different registers, four in a row.
    for (int i = 0; i < 4; i++)
      sb_step(1'b1, 3'd1, 32'hA000 + 32'(i), 1'b1, 3'd4, 32'hB000 + 32'(i));
    idle(6);

    // ALU streaming alone.
    for (int i = 0; i < 6; i++)
      sb_step(1'b1, 3'(i), 32'hC000 + 32'(i), 1'b0, 3'd0, 32'd0);
    idle(4);

    // Both requesters saturated: buffers fill and ready must drop.
    for (int i = 0; i < 20; i++)
      sb_step(1'b1, 3'($urandom_range(0, 7)), 32'h1_0000 + 32'(i),
              1'b1, 3'($urandom_range(0, 7)), 32'h2_0000 + 32'(i));
    idle(8);

    // Random traffic across many stamp-counter wraps.
    for (int i = 0; i < 150; i++)
      sb_step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
              1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom);
    idle(8);

    // Reset with three entries buffered and a write in the output stage.
    sb_step(1'b1, 3'd1, 32'hD001, 1'b1, 3'd2, 32'hD002);
    sb_step(1'b1, 3'd3, 32'hD003, 1'b1, 3'd4, 32'hD004);
    check("pre_rst_wr_en", 32'(wr_en), 32'd1);
    apply_reset();
    idle(6);

    // Requests at counter values 6, 7 and 0: ordering across the wrap.
    sb_step(1'b1, 3'd1, 32'hE006, 1'b1, 3'd2, 32'hF006);
    sb_step(1'b1, 3'd3, 32'hE007, 1'b1, 3'd4, 32'hF007);
    sb_step(1'b1, 3'd5, 32'hE000, 1'b1, 3'd6, 32'hF000);
    idle(8);

    sb_step(1'b1, 3'd3, 32'hDEADBEEF, 1'b0, 3'd0, 32'd0);
    idle(3);

    check("sb_leftover_writes", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
